// File: rtl/batch_mul_arbiter.sv
// -----------------------------------------------------------------------------
// batch_mul_arbiter
//
// Shares one pipelined signed x unsigned multiplier between NUM_REQ requesting
// kernels. A round-robin scan starting at the rotating pointer picks one valid
// requester per cycle. Its operands enter a MUL_STAGES-deep pipeline. Products
// leave in acceptance order, tagged with the requester index.
//
// Ports
//   ap_clk      in   clock, rising edge
//   ap_rst      in   asynchronous active-high reset
//   req_valid   in   [NUM_REQ]           per-requester operand valid
//   req_ready   out  [NUM_REQ]           per-requester accept (one-hot or zero)
//   req_a       in   [NUM_REQ*A_WIDTH]   packed signed operands
//   req_b       in   [NUM_REQ*B_WIDTH]   packed unsigned operands
//   resp_valid  out  product valid
//   resp_ready  in   consumer accepts product
//   resp_id     out  [ID_WIDTH]          requester index of the product
//   resp_p      out  [P_WIDTH]           signed full-precision product
//   busy_cnt    out  [32]                cycles with an accepted operand
//
// Optional feature macro: BATCH_MUL_ARB_STATS_EN
//   defined     -> busy_cnt counts accepted transfers (wraps at 2^32)
//   not defined -> busy_cnt is tied to zero and no counter is built
// -----------------------------------------------------------------------------
module batch_mul_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int A_WIDTH    = 26,
  parameter int B_WIDTH    = 9,
  parameter int P_WIDTH    = 35,
  parameter int MUL_STAGES = 2,
  parameter int ID_WIDTH   = 3
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]   req_b,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [ID_WIDTH-1:0]          resp_id,
  output logic [P_WIDTH-1:0]           resp_p,
  output logic [31:0]                  busy_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      r_ptr;
  logic [MUL_STAGES-1:0] r_vld;
  logic [ID_WIDTH-1:0]   r_id [MUL_STAGES];
  logic [P_WIDTH-1:0]    r_p  [MUL_STAGES];

  logic                  w_advance;
  logic                  w_found;
  logic [PTR_W-1:0]      w_win;
  logic [PTR_W-1:0]      w_ptr_next;
  logic                  w_take;
  logic [A_WIDTH-1:0]    w_a;
  logic [B_WIDTH-1:0]    w_b;
  logic [P_WIDTH-1:0]    w_ax;
  logic [P_WIDTH-1:0]    w_bx;
  logic [P_WIDTH-1:0]    w_prod;

  // The whole pipeline moves only when the output slot is empty or drained.
  assign w_advance = ~r_vld[MUL_STAGES-1] | resp_ready;

  // Round-robin scan: first valid requester at or after the pointer.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = idx[PTR_W-1:0];
      end
    end
  end

  // Reset holds every ready low so no transfer can be claimed mid-reset.
  assign w_take = w_found & w_advance & ~ap_rst;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready[gi] = w_take & (w_win == PTR_W'(gi));
  end

  assign w_ptr_next = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;

  // b is zero-extended before the signed multiply so it is never read as
  // negative; both operands are widened to the full product width.
  assign w_a    = req_a[w_win*A_WIDTH +: A_WIDTH];
  assign w_b    = req_b[w_win*B_WIDTH +: B_WIDTH];
  assign w_ax   = P_WIDTH'($signed(w_a));
  assign w_bx   = P_WIDTH'($signed({1'b0, w_b}));
  assign w_prod = P_WIDTH'($signed(w_ax) * $signed(w_bx));

  // Stage 0 captures the product; later stages are pure delay so that
  // synthesis can retime the multiplier across them.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_ptr <= '0;
      r_vld <= '0;
      for (int s = 0; s < MUL_STAGES; s++) begin
        r_id[s] <= '0;
        r_p[s]  <= '0;
      end
    end else if (w_advance) begin
      r_vld[0] <= w_take;
      if (w_take) begin
        r_id[0] <= ID_WIDTH'(w_win);
        r_p[0]  <= w_prod;
        r_ptr   <= w_ptr_next;
      end
      for (int s = 1; s < MUL_STAGES; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_id[s]  <= r_id[s-1];
        r_p[s]   <= r_p[s-1];
      end
    end
  end

  assign resp_valid = r_vld[MUL_STAGES-1];
  assign resp_id    = r_id[MUL_STAGES-1];
  assign resp_p     = r_p[MUL_STAGES-1];

`ifdef BATCH_MUL_ARB_STATS_EN
  logic [31:0] r_busy_cnt;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_busy_cnt <= '0;
    end else if (w_take) begin
      r_busy_cnt <= r_busy_cnt + 32'd1;
    end
  end

  assign busy_cnt = r_busy_cnt;
`else
  assign busy_cnt = '0;
`endif

endmodule

// File: tb/tb_batch_mul_arbiter.sv
// -----------------------------------------------------------------------------
// tb_batch_mul_arbiter
//
// Directed stimulus for batch_mul_arbiter (NUM_REQ=4, MUL_STAGES=2). A
// behavioural model runs on every falling edge. It decides the expected grant
// from the round-robin rule and keeps a queue of expected {id, product} in
// acceptance order. Directed literal checks pin the model's arithmetic,
// latency, grant order, backpressure, reset and stats behaviour.
// -----------------------------------------------------------------------------
module tb_batch_mul_arbiter;

  localparam int N  = 4;
  localparam int AW = 26;
  localparam int BW = 9;
  localparam int PW = 35;
  localparam int MS = 2;
  localparam int IW = 3;

`ifdef BATCH_MUL_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            ap_clk;
  logic            ap_rst;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic            resp_valid;
  logic            resp_ready;
  logic [IW-1:0]   resp_id;
  logic [PW-1:0]   resp_p;
  logic [31:0]     busy_cnt;

  logic [AW-1:0]   a_arr [N];
  logic [BW-1:0]   b_arr [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_pack
    assign req_a[gi*AW +: AW] = a_arr[gi];
    assign req_b[gi*BW +: BW] = b_arr[gi];
  end

  batch_mul_arbiter #(
    .NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW),
    .MUL_STAGES(MS), .ID_WIDTH(IW)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_p     (resp_p),
    .busy_cnt   (busy_cnt)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Plain integer arithmetic: sign-extend a, zero-extend b.
  function automatic logic [PW-1:0] model_prod(input logic [AW-1:0] a, input logic [BW-1:0] b);
    longint sa;
    longint r;
    sa = longint'($signed(a));
    r  = sa * longint'({1'b0, b});
    return r[PW-1:0];
  endfunction

  typedef struct packed {
    logic [IW-1:0] id;
    logic [PW-1:0] p;
  } exp_t;

  exp_t   exp_q [$];
  int     m_ptr  = 0;
  int     m_busy = 0;

  // Model and compare process, sampled on the falling edge.
  always @(negedge ap_clk) begin
    logic         adv;
    logic         found;
    int           g;
    int           idx;
    logic [N-1:0] exp_rdy;
    exp_t         e;
    if (ap_rst) begin
      exp_q.delete();
      m_ptr  = 0;
      m_busy = 0;
      chk("rst_req_ready", 64'(req_ready), 64'd0);
    end else begin
      adv   = !resp_valid || resp_ready;
      found = 1'b0;
      g     = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!found && req_valid[idx]) begin
          found = 1'b1;
          g     = idx;
        end
      end
      exp_rdy = (found && adv) ? N'(1 << g) : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("busy_cnt", 64'(busy_cnt), STATS ? 64'(m_busy) : 64'd0);

      if (resp_valid && resp_ready) begin
        chk("resp_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          $display("resp id=%0d p=%09h (exp id=%0d p=%09h)", resp_id, resp_p, e.id, e.p);
          chk("resp_id", 64'(resp_id), 64'(e.id));
          chk("resp_p", 64'(resp_p), 64'(e.p));
        end
      end

      if (found && adv) begin
        e.id = IW'(g);
        e.p  = model_prod(a_arr[g], b_arr[g]);
        exp_q.push_back(e);
        m_ptr = (g + 1) % N;
        m_busy++;
      end
    end
  end

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
  endtask

  // One isolated transfer on requester idx; the product must show up exactly
  // MUL_STAGES edges after the accepting edge.
  task automatic single(input int idx, input logic [AW-1:0] a, input logic [BW-1:0] b,
                        input logic [PW-1:0] exp_p);
    step();
    a_arr[idx] = a;
    b_arr[idx] = b;
    req_valid  = N'(1 << idx);
    @(negedge ap_clk);
    chk("single_grant", 64'(req_ready), 64'(1 << idx));
    step();
    req_valid = '0;
    chk("single_not_early", 64'(resp_valid), 64'd0);
    step();
    chk("single_valid", 64'(resp_valid), 64'd1);
    chk("single_id", 64'(resp_id), 64'(idx));
    chk("single_p", 64'(resp_p), 64'(exp_p));
    $display("single req%0d a=%07h b=%03h p=%09h", idx, a, b, resp_p);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ap_rst     = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end

    // Reset state, with every requester asking.
    step();
    req_valid = '1;
    @(negedge ap_clk);
    chk("reset_ready", 64'(req_ready), 64'd0);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    chk("reset_resp_id", 64'(resp_id), 64'd0);
    chk("reset_resp_p", 64'(resp_p), 64'd0);
    chk("reset_busy", 64'(busy_cnt), 64'd0);
    step();
    req_valid = '0;
    ap_rst    = 1'b0;

    // Signed x unsigned extremes.
    single(0, 26'h3FFFFFF, 9'h1FF, 35'h7FFFFFE01);
    single(1, 26'h1FFFFFF, 9'h1FF, 35'h3FDFFFE01);
    single(2, 26'h2000000, 9'h1FF, 35'h402000000);
    single(3, 26'h0000005, 9'h000, 35'h000000000);
    repeat (2) step();

    // Round-robin from reset with all requesters valid.
    do_reset();
    a_arr[0] = 26'h3FFFF00; b_arr[0] = 9'd3;
    a_arr[1] = 26'd12345;   b_arr[1] = 9'h1FF;
    a_arr[2] = 26'h2000001; b_arr[2] = 9'd100;
    a_arr[3] = 26'd7;       b_arr[3] = 9'd0;
    step();
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge ap_clk);
      chk("rr_grant", 64'(req_ready), 64'(1 << (k % 4)));
    end

    // Backpressure with the pipeline full.
    step();
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge ap_clk);
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_resp_valid", 64'(resp_valid), 64'd1);
      chk("bp_resp_id", 64'(resp_id), 64'd2);
    end
    step();
    resp_ready = 1'b1;
    @(negedge ap_clk);
    chk("bp_resume_grant", 64'(req_ready), 64'd1);
    step();
    req_valid = '0;
    repeat (3) step();

    // Sparse: req2 alone, then req1 and req3 with the pointer at 3.
    req_valid = 4'b0100;
    @(negedge ap_clk);
    chk("sparse_req2", 64'(req_ready), 64'b0100);
    step();
    req_valid = 4'b1010;
    @(negedge ap_clk);
    chk("sparse_req3_first", 64'(req_ready), 64'b1000);
    step();
    @(negedge ap_clk);
    chk("sparse_req1_next", 64'(req_ready), 64'b0010);
    step();
    req_valid = '0;
    repeat (3) step();

    // Reset with two products in flight and the pointer away from 0.
    req_valid = '1;
    repeat (3) begin
      @(negedge ap_clk);
      step();
    end
    ap_rst = 1'b1;
    #1;
    chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd0);
    step();
    ap_rst = 1'b0;
    @(negedge ap_clk);
    chk("midrst_first_grant", 64'(req_ready), 64'd1);
    chk("midrst_no_stale", 64'(resp_valid), 64'd0);
    step();
    req_valid = '0;
    repeat (3) step();

    // Stats: 10 accepts over 25 cycles.
    do_reset();
    for (int k = 0; k < 25; k++) begin
      req_valid = (k < 20 && (k % 2) == 0) ? 4'b0001 : 4'b0000;
      step();
    end
    chk("stats_busy_cnt", 64'(busy_cnt), STATS ? 64'd10 : 64'd0);

    repeat (4) step();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
